frame_bank_scheduler: RTL and testbench

- Single-clock (48 MHz system domain) ping-pong bank manager for the 1-bit camera frame buffer.
- Decides which of two SPRAM banks the camera writer fills and which bank the reader (SPI/MCU side) may consume.
- Tracks bank ownership, signals frame availability, and drops frames safely when the reader falls behind.
- Receives the camera-domain frame-complete event as a toggle and synchronises it internally.

---
 rtl/frame_bank_scheduler.sv | 171 +++++++++++++++++
 tb/tb_frame_bank_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_scheduler.sv
// Ping-pong bank manager for the 1-bit camera frame buffer.
// The camera writer fills one SPRAM bank while the reader consumes the other.
// Frames are dropped safely when the reader falls behind.
// Ports:
//   clk, nreset          - 48 MHz system clock, async active-low reset
//   cam_frame_tgl        - frame-complete toggle from the cam_pclk domain
//   rd_start, rd_done    - 1-cycle reader claim / release pulses
//   wr_bank, rd_bank     - bank the writer targets / bank the reader addresses
//   buffer_ready         - a FULL bank is available and no bank is READING
//   frame_read_complete  - 1-cycle pulse on an accepted rd_done
//   rd_timeout           - 1-cycle pulse when a READING bank is force-released
//   frame_count          - completed frames seen (wraps)
//   drop_count           - frames discarded (saturates)
//   bank0/1_state        - debug: 0 FREE, 1 WRITING, 2 FULL, 3 READING
module frame_bank_scheduler #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FRAME_CNT_W  = 8,
   parameter logic [23:0] READ_TIMEOUT = 24'd4800000
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   cam_frame_tgl,
   input  logic                   rd_start,
   input  logic                   rd_done,
   output logic                   wr_bank,
   output logic                   rd_bank,
   output logic                   buffer_ready,
   output logic                   frame_read_complete,
   output logic                   rd_timeout,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic [FRAME_CNT_W-1:0] drop_count,
   output logic [1:0]             bank0_state,
   output logic [1:0]             bank1_state
);

   localparam int unsigned TMO_W = 24;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      WRITING = 2'd1,
      FULL    = 2'd2,
      READING = 2'd3
   } bank_st_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   tgl_q;
   logic                   frame_evt;

   bank_st_t               bank_q [2];
   bank_st_t               bank_d [2];
   logic                   wr_q, wr_d;
   logic                   rd_q, rd_d;
   logic                   rdy_q, rdy_d;
   logic                   frc_q, frc_d;
   logic                   tmo_pulse_q, tmo_pulse_d;
   logic [FRAME_CNT_W-1:0] fc_q, fc_d;
   logic [FRAME_CNT_W-1:0] dc_q, dc_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;

   logic                   oth;
   logic                   drop_inc;
   logic                   start_acc;
   logic                   reading_mid;
   logic                   reading_nxt;
   logic                   full_nxt;

   // Toggle crosses from cam_pclk; an event is any change at the chain output.
   assign frame_evt = sync_q[SYNC_STAGES-1] ^ tgl_q;

   // Next-state: rd_done, then timeout, then rd_start, then frame event,
   // each applied on top of the previous step's result.
   always_comb begin
      bank_d      = bank_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      fc_d        = fc_q;
      dc_d        = dc_q;
      tmo_d       = '0;
      frc_d       = 1'b0;
      tmo_pulse_d = 1'b0;
      drop_inc    = 1'b0;
      start_acc   = 1'b0;
      oth         = ~wr_q;

      if (rd_done) begin
         if (bank_q[0] == READING) begin
            bank_d[0] = FREE;
            frc_d     = 1'b1;
         end else if (bank_q[1] == READING) begin
            bank_d[1] = FREE;
            frc_d     = 1'b1;
         end
      end

      reading_mid = (bank_d[0] == READING) || (bank_d[1] == READING);
      if (reading_mid && (READ_TIMEOUT != '0) && (tmo_q == READ_TIMEOUT - TMO_W'(1))) begin
         for (int i = 0; i < 2; i++) begin
            if (bank_d[i] == READING) bank_d[i] = FREE;
         end
         tmo_pulse_d = 1'b1;
      end

      if (rd_start && rdy_q && (bank_d[rd_q] == FULL)) begin
         bank_d[rd_q] = READING;
         start_acc    = 1'b1;
      end

      if (frame_evt) begin
         fc_d = fc_q + FRAME_CNT_W'(1);
         if (bank_d[oth] == READING) begin
            // Reader holds the other bank: writer overwrites its own bank.
            drop_inc = 1'b1;
         end else begin
            if (bank_d[oth] == FULL) drop_inc = 1'b1;
            bank_d[wr_q] = FULL;
            bank_d[oth]  = WRITING;
            wr_d         = oth;
            rd_d         = wr_q;
         end
      end

      if (drop_inc && (dc_q != '1)) dc_d = dc_q + FRAME_CNT_W'(1);

      reading_nxt = (bank_d[0] == READING) || (bank_d[1] == READING);
      full_nxt    = (bank_d[0] == FULL) || (bank_d[1] == FULL);
      rdy_d       = full_nxt && !reading_nxt;

      if (!start_acc && reading_nxt && (READ_TIMEOUT != '0)) tmo_d = tmo_q + TMO_W'(1);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync_q      <= '0;
         tgl_q       <= 1'b0;
         bank_q[0]   <= WRITING;
         bank_q[1]   <= FREE;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         rdy_q       <= 1'b0;
         frc_q       <= 1'b0;
         tmo_pulse_q <= 1'b0;
         fc_q        <= '0;
         dc_q        <= '0;
         tmo_q       <= '0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], cam_frame_tgl};
         tgl_q       <= sync_q[SYNC_STAGES-1];
         bank_q      <= bank_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         rdy_q       <= rdy_d;
         frc_q       <= frc_d;
         tmo_pulse_q <= tmo_pulse_d;
         fc_q        <= fc_d;
         dc_q        <= dc_d;
         tmo_q       <= tmo_d;
      end
   end

   assign wr_bank             = wr_q;
   assign rd_bank             = rd_q;
   assign buffer_ready        = rdy_q;
   assign frame_read_complete = frc_q;
   assign rd_timeout          = tmo_pulse_q;
   assign frame_count         = fc_q;
   assign drop_count          = dc_q;
   assign bank0_state         = bank_q[0];
   assign bank1_state         = bank_q[1];

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler. Two instances share all inputs:
// dut uses the default timeout, dut_t uses READ_TIMEOUT=50.
module tb_frame_bank_scheduler;

   logic       clk;
   logic       nreset;
   logic       cam_frame_tgl;
   logic       rd_start;
   logic       rd_done;

   logic       wr_bank, rd_bank, buffer_ready, frc, tmo;
   logic [7:0] fc, dc;
   logic [1:0] b0, b1;

   logic       t_wr_bank, t_rd_bank, t_buffer_ready, t_frc, t_tmo;
   logic [7:0] t_fc, t_dc;
   logic [1:0] t_b0, t_b1;

   int passed = 0;
   int total  = 0;

   frame_bank_scheduler dut (
      .clk(clk), .nreset(nreset), .cam_frame_tgl(cam_frame_tgl),
      .rd_start(rd_start), .rd_done(rd_done),
      .wr_bank(wr_bank), .rd_bank(rd_bank), .buffer_ready(buffer_ready),
      .frame_read_complete(frc), .rd_timeout(tmo),
      .frame_count(fc), .drop_count(dc),
      .bank0_state(b0), .bank1_state(b1)
   );

   frame_bank_scheduler #(.READ_TIMEOUT(24'd50)) dut_t (
      .clk(clk), .nreset(nreset), .cam_frame_tgl(cam_frame_tgl),
      .rd_start(rd_start), .rd_done(rd_done),
      .wr_bank(t_wr_bank), .rd_bank(t_rd_bank), .buffer_ready(t_buffer_ready),
      .frame_read_complete(t_frc), .rd_timeout(t_tmo),
      .frame_count(t_fc), .drop_count(t_dc),
      .bank0_state(t_b0), .bank1_state(t_b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      nreset        = 1'b0;
      cam_frame_tgl = 1'b0;
      rd_start      = 1'b0;
      rd_done       = 1'b0;
      repeat (2) step();
      nreset = 1'b1;
      step();
   endtask

   // Spacing cycle, toggle, then three edges until the event is visible.
   task automatic frame();
      step();
      cam_frame_tgl = ~cam_frame_tgl;
      repeat (3) step();
   endtask

   task automatic pulse_start();
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
   endtask

   task automatic pulse_done();
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
   endtask

   initial begin
      // Reset state
      nreset        = 1'b0;
      cam_frame_tgl = 1'b0;
      rd_start      = 1'b0;
      rd_done       = 1'b0;
      repeat (2) step();
      chk("rst_b0", 32'(b0), 32'd1);
      chk("rst_b1", 32'(b1), 32'd0);
      chk("rst_wr", 32'(wr_bank), 32'd0);
      chk("rst_rd", 32'(rd_bank), 32'd0);
      chk("rst_rdy", 32'(buffer_ready), 32'd0);
      chk("rst_fc", 32'(fc), 32'd0);
      chk("rst_dc", 32'(dc), 32'd0);
      chk("rst_pulses", 32'({frc, tmo}), 32'd0);
      nreset = 1'b1;
      step();

      // rd_start ignored when nothing is ready
      pulse_start();
      chk("ign_start_b0", 32'(b0), 32'd1);

      // First frame: event lands on the third edge after the toggle
      step();
      cam_frame_tgl = 1'b1;
      repeat (2) step();
      chk("evt_lat_fc", 32'(fc), 32'd0);
      step();
      chk("f1_b0", 32'(b0), 32'd2);
      chk("f1_b1", 32'(b1), 32'd1);
      chk("f1_wr", 32'(wr_bank), 32'd1);
      chk("f1_rd", 32'(rd_bank), 32'd0);
      chk("f1_rdy", 32'(buffer_ready), 32'd1);
      chk("f1_fc", 32'(fc), 32'd1);

      // Read bank0 for 100 cycles
      pulse_start();
      chk("rd_b0", 32'(b0), 32'd3);
      chk("rd_rdy", 32'(buffer_ready), 32'd0);
      repeat (100) step();
      chk("rd_hold_b0", 32'(b0), 32'd3);
      chk("rd_no_frc", 32'(frc), 32'd0);
      pulse_done();
      chk("done_b0", 32'(b0), 32'd0);
      chk("done_frc", 32'(frc), 32'd1);
      chk("done_dc", 32'(dc), 32'd0);
      step();
      chk("done_frc_1cyc", 32'(frc), 32'd0);
      pulse_done();
      chk("stray_done_frc", 32'(frc), 32'd0);

      // Three frames with no reads
      do_reset();
      frame();
      chk("s3_f1_wr", 32'(wr_bank), 32'd1);
      chk("s3_f1_dc", 32'(dc), 32'd0);
      frame();
      chk("s3_f2_wr", 32'(wr_bank), 32'd0);
      chk("s3_f2_rd", 32'(rd_bank), 32'd1);
      chk("s3_f2_dc", 32'(dc), 32'd1);
      chk("s3_f2_b0", 32'(b0), 32'd1);
      chk("s3_f2_b1", 32'(b1), 32'd2);
      frame();
      chk("s3_f3_wr", 32'(wr_bank), 32'd1);
      chk("s3_f3_rd", 32'(rd_bank), 32'd0);
      chk("s3_f3_dc", 32'(dc), 32'd2);
      chk("s3_f3_rdy", 32'(buffer_ready), 32'd1);
      chk("s3_f3_fc", 32'(fc), 32'd3);

      // Frames arriving while bank0 is being read
      do_reset();
      frame();
      pulse_start();
      chk("s4_b0", 32'(b0), 32'd3);
      frame();
      chk("s4_f2_wr", 32'(wr_bank), 32'd1);
      chk("s4_f2_dc", 32'(dc), 32'd1);
      chk("s4_f2_b0", 32'(b0), 32'd3);
      chk("s4_f2_rdy", 32'(buffer_ready), 32'd0);
      frame();
      chk("s4_f3_wr", 32'(wr_bank), 32'd1);
      chk("s4_f3_dc", 32'(dc), 32'd2);
      chk("s4_f3_b0", 32'(b0), 32'd3);
      chk("s4_f3_rd", 32'(rd_bank), 32'd0);

      // rd_done coinciding with a frame event
      step();
      cam_frame_tgl = ~cam_frame_tgl;
      repeat (2) step();
      pulse_done();
      chk("co_b0", 32'(b0), 32'd1);
      chk("co_b1", 32'(b1), 32'd2);
      chk("co_wr", 32'(wr_bank), 32'd0);
      chk("co_rd", 32'(rd_bank), 32'd1);
      chk("co_dc", 32'(dc), 32'd2);
      chk("co_frc", 32'(frc), 32'd1);
      chk("co_fc", 32'(fc), 32'd4);
      chk("co_rdy", 32'(buffer_ready), 32'd1);

      // Timeout on the READ_TIMEOUT=50 instance
      do_reset();
      frame();
      pulse_start();
      chk("to_b0_reading", 32'(t_b0), 32'd3);
      repeat (49) step();
      chk("to_early", 32'(t_tmo), 32'd0);
      chk("to_early_b0", 32'(t_b0), 32'd3);
      step();
      chk("to_pulse", 32'(t_tmo), 32'd1);
      chk("to_b0_free", 32'(t_b0), 32'd0);
      chk("to_no_frc", 32'(t_frc), 32'd0);
      chk("to_rdy", 32'(t_buffer_ready), 32'd0);
      step();
      chk("to_pulse_1cyc", 32'(t_tmo), 32'd0);
      pulse_done();
      chk("to_late_done", 32'(t_frc), 32'd0);
      chk("to_late_b0", 32'(t_b0), 32'd0);

      // Mid-read reset abandons the read
      frame();
      pulse_start();
      nreset = 1'b0;
      #1;
      chk("mid_rst_b0", 32'(b0), 32'd1);
      chk("mid_rst_wr", 32'(wr_bank), 32'd0);
      step();
      chk("mid_rst_pulses", 32'({frc, tmo}), 32'd0);
      nreset = 1'b1;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
